// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC, issues one read at a time
// on the instruction memory channel and hands {inst, pc, fetch_err} to decode.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high; a raised valid and its payload stay put until
// that edge, and valid never drops without a transfer.
module ysyx_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,

  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,

  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_err,

  input  logic        npc_valid,
  input  logic [31:0] npc,

  output logic [31:0] fetch_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_R   = 2'd1,
    DELIVER  = 2'd2,
    WAIT_NPC = 2'd3
  } state_e;

  state_e state;

  logic   rresp_err;
  logic   npc_misaligned;

  assign rresp_err      = (imem_rresp != 2'b00);
  assign npc_misaligned = (npc[1:0] != 2'b00);

  assign imem_araddr = pc;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      inst         <= 32'h0;
      fetch_err    <= 1'b0;
      fetch_cnt    <= 32'h0;
      imem_arvalid <= 1'b0;
      imem_rready  <= 1'b0;
      inst_valid   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          // arvalid is held low through reset, so the first cycle out of
          // reset only raises it; the request is issued from then on.
          if (!imem_arvalid) begin
            imem_arvalid <= 1'b1;
          end else if (imem_arready) begin
            imem_arvalid <= 1'b0;
            imem_rready  <= 1'b1;
            state        <= WAIT_R;
          end
        end

        WAIT_R: begin
          if (imem_rvalid) begin
            inst        <= rresp_err ? 32'h0 : imem_rdata;
            fetch_err   <= rresp_err;
            imem_rready <= 1'b0;
            inst_valid  <= 1'b1;
            state       <= DELIVER;
          end
        end

        DELIVER: begin
          if (inst_ready) begin
            fetch_cnt  <= fetch_cnt + 32'd1;
            inst_valid <= 1'b0;
            state      <= WAIT_NPC;
          end
        end

        WAIT_NPC: begin
          if (npc_valid) begin
            pc <= npc;
            // A misaligned target never reaches the bus; it is reported to
            // decode directly as a faulting fetch at that PC.
            if (npc_misaligned) begin
              inst       <= 32'h0;
              fetch_err  <= 1'b1;
              inst_valid <= 1'b1;
              state      <= DELIVER;
            end else begin
              fetch_err    <= 1'b0;
              imem_arvalid <= 1'b1;
              state        <= FETCH;
            end
          end
        end
      endcase
    end
  end

  a_ar_hold: assert property (@(posedge clk) disable iff (rst)
    (imem_arvalid && !imem_arready) |=> (imem_arvalid && $stable(imem_araddr)));

  a_inst_hold: assert property (@(posedge clk) disable iff (rst)
    (inst_valid && !inst_ready) |=>
      (inst_valid && $stable(inst) && $stable(pc) && $stable(fetch_err)));

  a_one_channel: assert property (@(posedge clk) disable iff (rst)
    $onehot0({imem_arvalid, imem_rready, inst_valid}));

endmodule
